// File: rtl/vmicro16_flags_unit.sv
// vmicro16_flags_unit: compare -> flags pipeline plus branch-condition resolver.
// A compare is registered into stage S1 and written to the architectural
// flags register one edge later. Branches are resolved against the flags
// register and answered with a one-cycle br_done pulse.
// Optional feature macro: VMICRO16_FLAGS_FWD_EN (forward S1 flags to branch
// resolution so a branch need not wait for write-back).
module vmicro16_flags_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmp_valid,
  output logic        cmp_ready,
  input  logic [15:0] cmp_a,
  input  logic [15:0] cmp_b,
  output logic [3:0]  flags,
  input  logic        br_valid,
  input  logic [7:0]  br_cond,
  output logic        br_ready,
  output logic        br_done,
  output logic        br_taken,
  output logic        br_bad_cond
);

  // Branch condition encodings (ISA VMICRO16_OP_BR_* values)
  localparam logic [7:0] BR_U  = 8'h00;
  localparam logic [7:0] BR_E  = 8'h01;
  localparam logic [7:0] BR_NE = 8'h02;
  localparam logic [7:0] BR_G  = 8'h03;
  localparam logic [7:0] BR_L  = 8'h05;

  logic [3:0]  s1_flags_q, s1_flags_d;
  logic        s1_valid_q, s1_valid_d;
  logic [3:0]  flags_q, flags_d;
  logic        br_done_q, br_done_d;
  logic        br_taken_q, br_taken_d;
  logic        br_bad_q, br_bad_d;

  logic [16:0] sum;
  logic [15:0] diff;
  logic [3:0]  cmp_flags;
  logic [3:0]  res_flags;
  logic        br_accept;
  logic        cond_taken;
  logic        cond_bad;

  // The unit never stalls compares.
  assign cmp_ready = 1'b1;

`ifdef VMICRO16_FLAGS_FWD_EN
  // S1 flags are forwarded, so only a same-cycle compare holds a branch off.
  assign br_ready  = ~cmp_valid;
  assign res_flags = s1_valid_q ? s1_flags_q : flags_q;
`else
  // Branch must wait until any in-flight compare has written back.
  assign br_ready  = ~s1_valid_q & ~cmp_valid;
  assign res_flags = flags_q;
`endif

  assign br_accept = br_valid & br_ready;

  // Subtract as a + ~b + 1 and derive {N,Z,C,V}.
  always_comb begin
    sum       = {1'b0, cmp_a} + {1'b0, ~cmp_b} + 17'd1;
    diff      = sum[15:0];
    cmp_flags = {diff[15],
                 (diff == 16'h0000),
                 sum[16],
                 (cmp_a[15] != cmp_b[15]) && (diff[15] != cmp_a[15])};
  end

  // Evaluate the requested condition against the resolution flags.
  always_comb begin
    cond_taken = 1'b0;
    cond_bad   = 1'b0;
    case (br_cond)
      BR_U:    cond_taken = 1'b1;
      BR_E:    cond_taken = res_flags[2];
      BR_NE:   cond_taken = ~res_flags[2];
      BR_L:    cond_taken = res_flags[3] != res_flags[0];
      BR_G:    cond_taken = ~res_flags[2] && (res_flags[3] == res_flags[0]);
      default: cond_bad   = 1'b1;
    endcase
  end

  // Next-state for the compare pipeline and the branch result registers.
  always_comb begin
    s1_flags_d = s1_flags_q;
    s1_valid_d = 1'b0;
    flags_d    = flags_q;
    br_done_d  = 1'b0;
    br_taken_d = 1'b0;
    br_bad_d   = 1'b0;
    if (s1_valid_q) flags_d = s1_flags_q;
    if (cmp_valid) begin
      s1_flags_d = cmp_flags;
      s1_valid_d = 1'b1;
    end
    if (br_accept) begin
      br_done_d  = 1'b1;
      br_taken_d = cond_taken;
      br_bad_d   = cond_bad;
    end
  end

  // State registers; reset discards any compare still sitting in S1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_flags_q <= 4'b0000;
      s1_valid_q <= 1'b0;
      flags_q    <= 4'b0000;
      br_done_q  <= 1'b0;
      br_taken_q <= 1'b0;
      br_bad_q   <= 1'b0;
    end else begin
      s1_flags_q <= s1_flags_d;
      s1_valid_q <= s1_valid_d;
      flags_q    <= flags_d;
      br_done_q  <= br_done_d;
      br_taken_q <= br_taken_d;
      br_bad_q   <= br_bad_d;
    end
  end

  assign flags       = flags_q;
  assign br_done     = br_done_q;
  assign br_taken    = br_taken_q;
  assign br_bad_cond = br_bad_q;

endmodule
